// File: rtl/mul_seq32.sv
// Sequential 32x32->64 unsigned multiplier that reuses one 16x16 multiplier
// over four steps, with ready/valid handshakes on both sides.

module mul16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [31:0] p_o
);
   assign p_o = 32'(a_i) * 32'(b_i);
endmodule

module mul_seq32 #(
   parameter int PIPE_MUL = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inA,
   input  logic [31:0] inB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

   state_e      state_q;
   logic [1:0]  step_q;
   logic [31:0] a_q, b_q;
   logic [63:0] acc_q;
   logic        pv_q;
   logic [31:0] prod_q;
   logic        in_ready_q, out_valid_q, busy_q;

   logic [15:0] mul_a, mul_b;
   logic [31:0] mul_p;

   // Step bit 0 picks the A half, bit 1 picks the B half.
   always_comb begin
      mul_a = step_q[0] ? a_q[31:16] : a_q[15:0];
      mul_b = step_q[1] ? b_q[31:16] : b_q[15:0];
   end

   mul16 u_mul16 (
      .a_i(mul_a),
      .b_i(mul_b),
      .p_o(mul_p)
   );

   function automatic logic [63:0] align(input logic [31:0] p, input logic [1:0] k);
      case (k)
         2'd0:    align = {32'd0, p};
         2'd3:    align = {p, 32'd0};
         default: align = {16'd0, p, 16'd0};
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= 2'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         acc_q       <= 64'd0;
         pv_q        <= 1'b0;
         prod_q      <= 32'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= inA;
                  b_q        <= inB;
                  acc_q      <= 64'd0;
                  step_q     <= 2'd0;
                  pv_q       <= 1'b0;
                  state_q    <= MUL;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            MUL: begin
               if (PIPE_MUL == 0) begin
                  acc_q  <= acc_q + align(mul_p, step_q);
                  step_q <= step_q + 2'd1;
                  if (step_q == 2'd3) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end else begin
                  // A registered product always belongs to the step before step_q;
                  // step_q wraps to 0 once step 3 has been issued.
                  if (pv_q)
                     acc_q <= acc_q + align(prod_q, step_q - 2'd1);
                  if (pv_q && step_q == 2'd0) begin
                     pv_q        <= 1'b0;
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     prod_q <= mul_p;
                     pv_q   <= 1'b1;
                     step_q <= step_q + 2'd1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out       = acc_q;
endmodule
